// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : btn_pkg
// Purpose : Shared types and helpers for the button conditioner.
//           - db_state_t    : per-channel debounce FSM state
//           - btn_cnt_width : width of a counter that must hold the largest
//                             of the debounce / hold / repeat counts
// Config  : none (BTN_AUTOREPEAT_EN is consumed by btn_channel)
// Revision: 1.0 - initial multi-channel release
// ============================================================================
package btn_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  // One shared width for every counter so a single constant set covers all.
  // Clamped to 1 so a degenerate all-zero configuration still elaborates.
  function automatic int btn_cnt_width(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    int          w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// Module  : btn_channel
// Purpose : One button channel: synchroniser, debounce FSM, one-cycle
//           rise/fall pulses, long-press hold level and optional auto-repeat.
// Ports   : clk_in    - system clock
//           rst_n_in  - asynchronous active-low reset
//           raw_in    - raw asynchronous button pin
//           clean_out - debounced level, 1 = pressed
//           rise_out  - one-cycle press pulse (plus repeats when enabled)
//           fall_out  - one-cycle release pulse
//           hold_out  - 1 while pressed for at least HOLD_COUNT cycles
// Config  : `define BTN_AUTOREPEAT_EN to generate the auto-repeat logic.
// Revision: 1.0 - initial multi-channel release
// ============================================================================
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DB_COUNT     = 650_000,
  parameter int unsigned HOLD_COUNT   = 65_000_000,
  parameter int unsigned REPEAT_COUNT = 13_000_000,
  parameter logic        INVERT       = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_in,
  output logic clean_out,
  output logic rise_out,
  output logic fall_out,
  output logic hold_out
);

  localparam int             CW          = btn_cnt_width(DB_COUNT, HOLD_COUNT, REPEAT_COUNT);
  localparam logic [CW-1:0]  C_DB_LAST   = CW'(DB_COUNT - 1);
  localparam logic [CW-1:0]  C_HOLD      = CW'(HOLD_COUNT);
  localparam logic [CW-1:0]  C_HOLD_LAST = CW'(HOLD_COUNT - 1);
  localparam logic [CW-1:0]  C_ONE       = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  db_state_t              r_state;
  logic [CW-1:0]          r_db_cnt;
  logic [CW-1:0]          r_hold_cnt;
  logic                   r_clean;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_hold;
  logic                   w_toggle;
  logic                   w_fall_evt;
  logic                   w_rep_fire;

  // The polarity fix is applied on the way into the chain so the reset value
  // of every stage means "released"; an active-low button that is already
  // pressed at reset release then fills the chain like any other press.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_sync <= '0;
    else           r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in ^ INVERT};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Last qualifying cycle of a debounce run: clean flips on this edge.
  assign w_toggle   = (r_state == COUNTING) && (w_s != r_clean) && (r_db_cnt >= C_DB_LAST);
  assign w_fall_evt = w_toggle && r_clean;

  // Debounce FSM with registered level and edge pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= STABLE;
      r_db_cnt <= '0;
      r_clean  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= w_rep_fire;
      r_fall <= 1'b0;
      case (r_state)
        STABLE: begin
          r_db_cnt <= '0;
          if (w_s != r_clean) begin
            r_state  <= COUNTING;
            r_db_cnt <= C_ONE;
          end
        end
        COUNTING: begin
          if (w_s == r_clean) begin
            // glitch shorter than the debounce window: discard silently
            r_state  <= STABLE;
            r_db_cnt <= '0;
          end else if (w_toggle) begin
            r_state  <= STABLE;
            r_db_cnt <= '0;
            r_clean  <= ~r_clean;
            r_rise   <= ~r_clean;
            r_fall   <= r_clean;
          end else begin
            r_db_cnt <= r_db_cnt + C_ONE;
          end
        end
        default: begin
          r_state  <= STABLE;
          r_db_cnt <= '0;
        end
      endcase
    end
  end

  // Long-press detection. The counter runs off the registered level, and the
  // release edge clears hold in the same cycle fall pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else if (!r_clean || w_fall_evt) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else if (r_hold_cnt < C_HOLD) begin
      r_hold_cnt <= r_hold_cnt + C_ONE;
      if (r_hold_cnt == C_HOLD_LAST) r_hold <= 1'b1;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] C_REP_LAST = CW'(REPEAT_COUNT - 1);

  logic [CW-1:0] r_rep_cnt;

  // First repeat lands REPEAT_COUNT cycles after hold rises; no repeat is
  // allowed on the release edge itself.
  assign w_rep_fire = r_hold && !w_fall_evt && (r_rep_cnt >= C_REP_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                      r_rep_cnt <= '0;
    else if (!r_hold || w_fall_evt)     r_rep_cnt <= '0;
    else if (w_rep_fire)                r_rep_cnt <= '0;
    else                                r_rep_cnt <= r_rep_cnt + C_ONE;
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign clean_out = r_clean;
  assign rise_out  = r_rise;
  assign fall_out  = r_fall;
  assign hold_out  = r_hold;

endmodule : btn_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : button_conditioner
// Purpose : NUM_CH independent button channels (sync + debounce + edge
//           pulses + long-press hold) for the board pushbuttons.
// Ports   : clk_in    - system clock (65 MHz)
//           rst_n_in  - asynchronous active-low reset
//           raw_in    - raw asynchronous button pins [NUM_CH]
//           clean_out - debounced levels, 1 = pressed [NUM_CH]
//           rise_out  - one-cycle press pulses [NUM_CH]
//           fall_out  - one-cycle release pulses [NUM_CH]
//           hold_out  - long-press levels [NUM_CH]
// Config  : `define BTN_AUTOREPEAT_EN to enable auto-repeat on rise_out.
// Revision: 1.0 - initial multi-channel release
// ============================================================================
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned       NUM_CH       = 5,
  parameter int unsigned       SYNC_STAGES  = 2,
  parameter int unsigned       DB_COUNT     = 650_000,
  parameter int unsigned       HOLD_COUNT   = 65_000_000,
  parameter int unsigned       REPEAT_COUNT = 13_000_000,
  parameter logic [NUM_CH-1:0] INVERT_MASK  = '0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] rise_out,
  output logic [NUM_CH-1:0] fall_out,
  output logic [NUM_CH-1:0] hold_out
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_COUNT     (DB_COUNT),
      .HOLD_COUNT   (HOLD_COUNT),
      .REPEAT_COUNT (REPEAT_COUNT),
      .INVERT       (INVERT_MASK[i])
    ) u_channel (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .raw_in    (raw_in[i]),
      .clean_out (clean_out[i]),
      .rise_out  (rise_out[i]),
      .fall_out  (fall_out[i]),
      .hold_out  (hold_out[i])
    );
  end

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_conditioner
// Purpose : Directed self-checking bench for button_conditioner with
//           NUM_CH=3, SYNC_STAGES=2, DB_COUNT=4, HOLD_COUNT=16,
//           REPEAT_COUNT=5, INVERT_MASK=3'b100. Expectations follow the
//           BTN_AUTOREPEAT_EN setting of the build.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk_in;
  logic       rst_n_in;
  logic [2:0] raw_in;
  logic [2:0] clean_out;
  logic [2:0] rise_out;
  logic [2:0] fall_out;
  logic [2:0] hold_out;

  int n_cmp  = 0;
  int n_fail = 0;

  button_conditioner #(
    .NUM_CH       (3),
    .SYNC_STAGES  (2),
    .DB_COUNT     (4),
    .HOLD_COUNT   (16),
    .REPEAT_COUNT (5),
    .INVERT_MASK  (3'b100)
  ) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_out  (rise_out),
    .fall_out  (fall_out),
    .hold_out  (hold_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph, input int k,
                           input logic [2:0] e_clean, input logic [2:0] e_rise,
                           input logic [2:0] e_fall,  input logic [2:0] e_hold);
    check($sformatf("%s[%0d].clean", ph, k), clean_out, e_clean);
    check($sformatf("%s[%0d].rise",  ph, k), rise_out,  e_rise);
    check($sformatf("%s[%0d].fall",  ph, k), fall_out,  e_fall);
    check($sformatf("%s[%0d].hold",  ph, k), hold_out,  e_hold);
  endtask

  initial begin
    // Reset with ch2 (active-low) already pressed at the pin.
    rst_n_in = 1'b0;
    raw_in   = 3'b000;
    repeat (3) @(negedge clk_in);
    check_all("reset", 0, 3'b000, 3'b000, 3'b000, 3'b000);

    // Phase A: ch2 pressed at reset release -> rise 6 edges later.
    rst_n_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      check_all("invpress", k, (k >= 6) ? 3'b100 : 3'b000,
                (k == 6) ? 3'b100 : 3'b000, 3'b000, 3'b000);
    end

    // Phase A2: release ch2 (pin back high) -> fall 6 edges later.
    raw_in[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      check_all("invrel", k, (k < 6) ? 3'b100 : 3'b000, 3'b000,
                (k == 6) ? 3'b100 : 3'b000, 3'b000);
    end

    // Phase B: ch0 held 40 cycles; ch1 sees a 3-cycle glitch.
    raw_in[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      logic r0;
      @(negedge clk_in);
      r0 = (k == 6) || (AR && (k == 27 || k == 32 || k == 37));
      check_all("press", k, (k >= 6) ? 3'b001 : 3'b000, {2'b00, r0},
                3'b000, (k >= 22) ? 3'b001 : 3'b000);
      if (k == 2) raw_in[1] = 1'b1;
      if (k == 5) raw_in[1] = 1'b0;
    end

    // Phase C: release ch0 after hold -> fall and hold drop together.
    raw_in[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      check_all("release", k, (k < 6) ? 3'b001 : 3'b000,
                (AR && k == 2) ? 3'b001 : 3'b000,
                (k == 6) ? 3'b001 : 3'b000,
                (k < 6) ? 3'b001 : 3'b000);
    end

    // Phase D: press ch1 fully, then start ch0 and reset mid-count.
    raw_in[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      check_all("ch1press", k, (k >= 6) ? 3'b010 : 3'b000,
                (k == 6) ? 3'b010 : 3'b000, 3'b000, 3'b000);
    end
    raw_in[0] = 1'b1;
    repeat (4) @(negedge clk_in);   // ch0 debounce count now at 2
    rst_n_in = 1'b0;
    #1;
    check_all("midrst", 0, 3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clk_in);
    check_all("inrst", 0, 3'b000, 3'b000, 3'b000, 3'b000);

    // Both held channels restart as fresh presses and rise together.
    rst_n_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      check_all("afterrst", k, (k >= 6) ? 3'b011 : 3'b000,
                (k == 6) ? 3'b011 : 3'b000, 3'b000, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_button_conditioner
`default_nettype wire
